// File: rtl/minesweeper_input.sv
// Button conditioner for the minesweeper core: 2-flop sync, per-bit debounce, one-cycle step pulses.
// Optional per-direction auto-repeat is built when MINESWEEPER_AUTOREPEAT_EN is defined.
module minesweeper_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_level,
  output logic       step_left,
  output logic       step_right,
  output logic       step_up,
  output logic       step_down,
  output logic       step_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic [4:0] sync1_reg;
  logic [4:0] sync2_reg;
  logic [4:0] level_int;
  logic [4:0] rise;
  logic [3:0] rep_fire;
  logic [3:0] dir_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn_in;
      sync2_reg <= sync1_reg;
    end
  end

  // level_int leads btn_level by one cycle so the pulse and the level appear together
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_deb
      logic [DW-1:0] cnt_reg;
      logic          lvl_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
          lvl_reg <= 1'b0;
        end else if (sync2_reg[gi] == lvl_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_reg <= '0;
          lvl_reg <= ~lvl_reg;
        end else begin
          cnt_reg <= cnt_reg + DW'(1);
        end
      end

      assign level_int[gi] = lvl_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) btn_level <= '0;
    else     btn_level <= level_int;
  end

  assign rise = level_int & ~btn_level;

`ifdef MINESWEEPER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_rep
      rep_state_t    state_reg;
      logic [RW-1:0] rcnt_reg;
      logic          fire;

      // A fire requires the internal level still high, so a release kills the pending pulse
      assign fire = level_int[gi] &&
                    (((state_reg == DELAY)  && (rcnt_reg == RW'(REPEAT_DELAY - 1))) ||
                     ((state_reg == REPEAT) && (rcnt_reg == RW'(REPEAT_PERIOD - 1))));
      assign rep_fire[gi] = fire;

      always_ff @(posedge clk) begin
        if (rst || !level_int[gi]) begin
          state_reg <= IDLE;
          rcnt_reg  <= '0;
        end else if (rise[gi]) begin
          state_reg <= DELAY;
          rcnt_reg  <= '0;
        end else begin
          case (state_reg)
            DELAY: begin
              if (fire) begin
                state_reg <= REPEAT;
                rcnt_reg  <= '0;
              end else begin
                rcnt_reg <= rcnt_reg + RW'(1);
              end
            end
            REPEAT: begin
              if (fire) rcnt_reg <= '0;
              else      rcnt_reg <= rcnt_reg + RW'(1);
            end
            default: begin
              state_reg <= IDLE;
              rcnt_reg  <= '0;
            end
          endcase
        end
      end
    end
  endgenerate
`else
  assign rep_fire = '0;
`endif

  assign dir_pulse = rise[3:0] | rep_fire;

  // Opposing directions firing together cancel each other
  always_ff @(posedge clk) begin
    if (rst) begin
      step_left  <= 1'b0;
      step_right <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      step_press <= 1'b0;
    end else begin
      step_left  <= dir_pulse[0] & ~dir_pulse[1];
      step_right <= dir_pulse[1] & ~dir_pulse[0];
      step_up    <= dir_pulse[2] & ~dir_pulse[3];
      step_down  <= dir_pulse[3] & ~dir_pulse[2];
      step_press <= rise[4];
    end
  end

endmodule

// File: tb/tb_minesweeper_input.sv
// Scoreboard bench for minesweeper_input: a run-length reference model predicts every output cycle.
module tb_minesweeper_input;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk;
  logic       rst;
  logic [4:0] btn_in;
  logic [4:0] btn_level;
  logic       step_left, step_right, step_up, step_down, step_press;

  minesweeper_input #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .step_left(step_left),
    .step_right(step_right),
    .step_up(step_up),
    .step_down(step_down),
    .step_press(step_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] lvl;
    logic [4:0] stp;
  } exp_t;

  exp_t q[$];
  int   assertions = 0;
  int   failures   = 0;
  int   cycle      = 0;
  int   pulse_cnt[5];

`ifdef MINESWEEPER_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // Reference model: level = value of the latest run of D equal synchronised samples;
  // repeats occur at ages RD, RD+RP, ... after the initial pulse while the level stays high.
  logic [4:0] x_d1 = '0, x_d2 = '0;
  logic       r_d1 = 1'b0, r_d2 = 1'b0;
  logic [4:0] int_lvl = '0, out_lvl = '0, runval = '0;
  int         runlen[5];
  int         age[5];

  always @(posedge clk) begin
    exp_t       e;
    logic [4:0] z, nl, rs, pulse;
    e = '0;
    if (rst) begin
      int_lvl = '0;
      out_lvl = '0;
      runval  = '0;
      for (int i = 0; i < 5; i++) begin
        runlen[i] = 0;
        age[i]    = 0;
      end
    end else begin
      z  = (r_d1 || r_d2) ? 5'b0 : x_d2;
      nl = int_lvl;
      for (int i = 0; i < 5; i++) begin
        if (runlen[i] > 0 && z[i] == runval[i]) begin
          if (runlen[i] < D) runlen[i]++;
        end else begin
          runval[i] = z[i];
          runlen[i] = 1;
        end
        if (runlen[i] >= D) int_lvl[i] = runval[i];
      end
      rs    = nl & ~out_lvl;
      pulse = rs;
      for (int i = 0; i < 4; i++) begin
        if (nl[i]) begin
          if (rs[i]) age[i] = 0;
          else       age[i]++;
          if (AUTO && !rs[i] && age[i] >= RD && ((age[i] - RD) % RP) == 0) pulse[i] = 1'b1;
        end else begin
          age[i] = 0;
        end
      end
      e.lvl    = nl;
      e.stp[0] = pulse[0] & ~pulse[1];
      e.stp[1] = pulse[1] & ~pulse[0];
      e.stp[2] = pulse[2] & ~pulse[3];
      e.stp[3] = pulse[3] & ~pulse[2];
      e.stp[4] = pulse[4];
      out_lvl  = nl;
    end
    x_d2 = x_d1;
    x_d1 = btn_in;
    r_d2 = r_d1;
    r_d1 = rst;
    q.push_back(e);
  end

  // Monitor: one comparison per output cycle, sampled on the falling edge
  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] stp;
    cycle++;
    stp = {step_press, step_down, step_up, step_right, step_left};
    if (q.size() > 0) begin
      e = q.pop_front();
      assertions++;
      if (btn_level !== e.lvl || stp !== e.stp) begin
        failures++;
        $display("FAIL outputs cycle %0d: got level=%b steps=%b, expected level=%b steps=%b",
                 cycle, btn_level, stp, e.lvl, e.stp);
      end
    end
    for (int i = 0; i < 5; i++) if (stp[i] === 1'b1) pulse_cnt[i]++;
    if (stp != 5'b0) $display("cycle %0d step pulse steps=%b level=%b", cycle, stp, btn_level);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) pulse_cnt[i] = 0;
  endtask

  task automatic check_count(input string name, input int got, input int exp_v);
    assertions++;
    if (got != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d pulses, expected %0d", name, got, exp_v);
    end else begin
      $display("check %s: %0d pulses", name, got);
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    clear_counts();
    tick(3);
    rst = 1'b0;
    tick(3);

    // Clean press and release
    clear_counts();
    btn_in[4] = 1'b1; tick(20);
    btn_in[4] = 1'b0; tick(12);
    check_count("clean_press", pulse_cnt[4], 1);

    // Bounce and a 3-cycle glitch
    clear_counts();
    btn_in[0] = 1'b1; tick(1);
    btn_in[0] = 1'b0; tick(1);
    btn_in[0] = 1'b1; tick(1);
    btn_in[0] = 1'b0; tick(10);
    btn_in[0] = 1'b1; tick(3);
    btn_in[0] = 1'b0; tick(10);
    check_count("bounce_left", pulse_cnt[0], 0);

    // Left/right coincide
    clear_counts();
    btn_in[1:0] = 2'b11; tick(15);
    btn_in[1:0] = 2'b00; tick(12);
    check_count("conflict_left", pulse_cnt[0], 0);
    check_count("conflict_right", pulse_cnt[1], 0);

    // Up one cycle ahead of down
    clear_counts();
    btn_in[2] = 1'b1; tick(1);
    btn_in[3] = 1'b1; tick(15);
    btn_in[3:2] = 2'b00; tick(12);
    check_count("offset_up", pulse_cnt[2], AUTO ? 3 : 1);
    check_count("offset_down", pulse_cnt[3], AUTO ? 3 : 1);

    // Reset while down is held
    clear_counts();
    btn_in[3] = 1'b1; tick(8);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(20);
    btn_in[3] = 1'b0; tick(12);
    check_count("reset_hold_down", pulse_cnt[3], AUTO ? 6 : 2);

    // Long hold of right, then of press
    clear_counts();
    btn_in[1] = 1'b1; tick(40);
    btn_in[1] = 1'b0; tick(12);
    check_count("hold_right", pulse_cnt[1], AUTO ? 11 : 1);
    clear_counts();
    btn_in[4] = 1'b1; tick(40);
    btn_in[4] = 1'b0; tick(12);
    check_count("hold_press", pulse_cnt[4], 1);

    // Random toggling with occasional resets
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(7) == 0) btn_in[b] = ~btn_in[b];
      rst = ($urandom_range(299) == 0);
      tick(1);
    end
    rst    = 1'b0;
    btn_in = '0;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
